// File: rtl/router_pkg.sv
// Constants shared with the router input FSM: header layout, illegal port, tx states.
// Header byte is {payload length, destination port}; port 3 does not exist.
package router_pkg;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MAX_LEN = 63;
   localparam int ADDR_W      = 2;
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PARITY  = 3'd3,
      ST_DONE    = 3'd4
   } tx_state_e;
endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: register array filled in order, combinational read, cleared by flush.
// Single-cycle write; a write while full is ignored (the caller reports the error).
module router_tx_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 63,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              flush_i,
   input  logic [CNT_W-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  count_q;
   logic              wr_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign wr_ok   = wr_en_i && !full_o && !flush_i;
   assign count_o = count_q;

   // Buffer only drains by flush, so the count doubles as the write pointer.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         count_q <= '0;
      end else if (wr_ok) begin
         count_q <= count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem_q[count_q] <= wr_data_i;
      end
   end

   assign rd_data_o = (rd_addr_i < CNT_W'(DEPTH)) ? mem_q[rd_addr_i] : '0;
endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for a router port: header, buffered payload, then XOR parity byte.
// Header appears 1 cycle after start; each byte is held until an edge with busy low.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] dest_addr_i,
   input  logic              abort_i,
   input  logic              busy_i,
   output logic              pkt_valid_o,
   output logic [DATA_W-1:0] data_out_o,
   output logic              tx_busy_o,
   output logic              tx_done_o,
   output logic              err_o,
   output logic [5:0]        buf_count_o
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam int LEN_W = DATA_W - ADDR_W;

   tx_state_e         state_q;
   logic [CNT_W-1:0]  rd_ptr_q, rd_addr_d, count, cnt_eff_d;
   logic [DATA_W-1:0] parity_q, data_out_q, rd_data, hdr_d;
   logic              pkt_valid_q, tx_busy_q, tx_done_q, err_q;
   logic              full, idle, wr_ok_d, start_ok_d, flush_d, last_d;

   assign idle       = (state_q == ST_IDLE);
   assign wr_ok_d    = wr_en_i && idle && !full && !abort_i;
   // A write in the same cycle as start is part of the packet.
   assign cnt_eff_d  = count + CNT_W'(wr_ok_d);
   assign start_ok_d = (cnt_eff_d != '0) && (dest_addr_i != ADDR_INVALID);
   assign hdr_d      = {LEN_W'(cnt_eff_d), dest_addr_i};
   assign flush_d    = abort_i || (state_q == ST_DONE);
   assign last_d     = (rd_ptr_q == count - 1'b1);
   assign rd_addr_d  = (state_q == ST_HEADER) ? '0 : rd_ptr_q + 1'b1;

   router_tx_buf #(.DATA_W(DATA_W), .DEPTH(MAX_LEN), .CNT_W(CNT_W)) u_buf (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (wr_ok_d),
      .wr_data_i (wr_data_i),
      .flush_i   (flush_d),
      .rd_addr_i (rd_addr_d),
      .rd_data_o (rd_data),
      .count_o   (count),
      .full_o    (full)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         rd_ptr_q    <= '0;
         parity_q    <= '0;
         data_out_q  <= '0;
         pkt_valid_q <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q     <= 1'b0;
         tx_done_q <= 1'b0;
         if (abort_i) begin
            state_q     <= ST_IDLE;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            tx_busy_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (wr_en_i && full) err_q <= 1'b1;
                  if (start_i && start_ok_d) begin
                     state_q     <= ST_HEADER;
                     parity_q    <= hdr_d;
                     data_out_q  <= hdr_d;
                     pkt_valid_q <= 1'b1;
                     tx_busy_q   <= 1'b1;
                  end else if (start_i) begin
                     err_q <= 1'b1;
                  end
               end
               ST_HEADER: begin
                  if (!busy_i) begin
                     state_q    <= ST_PAYLOAD;
                     rd_ptr_q   <= '0;
                     data_out_q <= rd_data;
                  end
               end
               ST_PAYLOAD: begin
                  // data_out_q holds the byte being accepted, so it folds straight into parity.
                  if (!busy_i) begin
                     parity_q <= parity_q ^ data_out_q;
                     if (last_d) begin
                        state_q     <= ST_PARITY;
                        pkt_valid_q <= 1'b0;
                        data_out_q  <= parity_q ^ data_out_q;
                     end else begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        data_out_q <= rd_data;
                     end
                  end
               end
               ST_PARITY: begin
                  if (!busy_i) begin
                     state_q    <= ST_DONE;
                     data_out_q <= '0;
                     tx_done_q  <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_q   <= ST_IDLE;
                  tx_busy_q <= 1'b0;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
         if (wr_en_i && !idle) err_q <= 1'b1;
      end
   end

   assign pkt_valid_o = pkt_valid_q;
   assign data_out_o  = data_out_q;
   assign tx_busy_o   = tx_busy_q;
   assign tx_done_o   = tx_done_q;
   assign err_o       = err_q;
   assign buf_count_o = 6'(count);
endmodule
